// File: rtl/gorev_denetleyici.sv
// Task scheduler for the 3x3 filter unit: queues kernel codes, loads the 9 coefficients,
// starts the unit and counts result handshakes until the full image has been produced.
`timescale 1ns/1ps
module gorev_denetleyici #(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16,
  parameter int COEF_BIT   = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int TOPLAM = IMG_WIDTH * IMG_HEIGHT,
  localparam int SW     = $clog2(TOPLAM + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          gorev_kod_i,
  input  logic                gorev_gecerli_i,
  output logic                gorev_hazir_o,
  output logic [COEF_BIT-1:0] filtre_veri_o,
  output logic [3:0]          filtre_idx_o,
  output logic                filtre_gecerli_o,
  output logic                tu_basla_o,
  output logic                tu_iptal_o,
  input  logic                res_gecerli_i,
  input  logic                res_hazir_i,
  output logic                gorev_bitti_o,
  output logic [1:0]          gorev_bitti_kod_o,
  output logic [SW-1:0]       islenen_sayac_o,
  output logic                mesgul_o,
  output logic                hata_o,
  input  logic                iptal_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {BOSTA, YUKLE, BASLA, CALIS, BITIR} durum_t;

  durum_t          state_q, state_d;
  logic [1:0]      fifo_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      k_q, k_d;
  logic [1:0]      aktif_q, aktif_d;
  logic [SW-1:0]   sayac_q, sayac_d;
  logic            hata_q, hata_d, iptal_q, iptal_d;
  logic            push, pop, hs;
  logic signed [COEF_BIT-1:0] coef;

  function automatic logic signed [3:0] rom(input logic [1:0] kod, input logic [3:0] k);
    logic signed [3:0] v;
    v = '0;
    case (kod)
      2'd0: case (k)
        4'd0, 4'd6: v = -4'sd1;
        4'd2, 4'd8: v = 4'sd1;
        4'd3:       v = -4'sd2;
        4'd5:       v = 4'sd2;
        default:    v = '0;
      endcase
      2'd1: case (k)
        4'd0, 4'd2: v = -4'sd1;
        4'd1:       v = -4'sd2;
        4'd6, 4'd8: v = 4'sd1;
        4'd7:       v = 4'sd2;
        default:    v = '0;
      endcase
      2'd2: case (k)
        4'd1, 4'd3, 4'd5, 4'd7: v = 4'sd1;
        4'd4:                   v = -4'sd4;
        default:                v = '0;
      endcase
      default: v = (k <= 4'd8) ? 4'sd1 : 4'sd0;
    endcase
    return v;
  endfunction

  assign hs            = res_gecerli_i && res_hazir_i;
  assign gorev_hazir_o = (cnt_q != CW'(FIFO_DEPTH)) && !iptal_i;
  assign push          = gorev_gecerli_i && gorev_hazir_o;
  assign coef          = COEF_BIT'(rom(aktif_q, k_q));

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    k_d     = k_q;
    aktif_d = aktif_q;
    sayac_d = sayac_q;
    hata_d  = hata_q;
    iptal_d = 1'b0;
    pop     = 1'b0;
    if (hs && state_q != CALIS) hata_d = 1'b1;
    if (push) wr_d = wr_q + AW'(1);
    case (state_q)
      BOSTA: if (cnt_q != '0) begin
        pop     = 1'b1;
        aktif_d = fifo_q[rd_q];
        k_d     = '0;
        state_d = YUKLE;
      end
      YUKLE: if (k_q == 4'd8) begin
        k_d     = '0;
        state_d = BASLA;
      end else begin
        k_d = k_q + 4'd1;
      end
      BASLA: begin
        sayac_d = '0;
        state_d = CALIS;
      end
      CALIS: if (hs) begin
        sayac_d = sayac_q + SW'(1);
        if (sayac_q == SW'(TOPLAM - 1)) state_d = BITIR;
      end
      BITIR:   state_d = BOSTA;
      default: state_d = BOSTA;
    endcase
    if (pop) rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    // Abort wins over everything, including a completion landing on the same edge.
    if (iptal_i) begin
      state_d = BOSTA;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      k_d     = '0;
      sayac_d = '0;
      iptal_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BOSTA;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      aktif_q <= '0;
      sayac_q <= '0;
      hata_q  <= 1'b0;
      iptal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      aktif_q <= aktif_d;
      sayac_q <= sayac_d;
      hata_q  <= hata_d;
      iptal_q <= iptal_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) fifo_q[wr_q] <= gorev_kod_i;
  end

  assign filtre_gecerli_o  = (state_q == YUKLE);
  assign filtre_idx_o      = filtre_gecerli_o ? k_q : '0;
  assign filtre_veri_o     = filtre_gecerli_o ? coef : '0;
  assign tu_basla_o        = (state_q == BASLA);
  assign tu_iptal_o        = iptal_q;
  assign gorev_bitti_o     = (state_q == BITIR);
  assign gorev_bitti_kod_o = gorev_bitti_o ? aktif_q : '0;
  assign islenen_sayac_o   = sayac_q;
  assign mesgul_o          = (state_q != BOSTA);
  assign hata_o            = hata_q;
endmodule

// File: tb/tb_gorev_denetleyici.sv
// Bench for gorev_denetleyici: randomized result traffic against a cycle model built from
// the task queue, kernel table and per-task phase sequence.
`timescale 1ns/1ps
module tb_gorev_denetleyici;
  localparam int W = 16, H = 16, CB = 8, D = 4;
  localparam int TOT = W * H;
  localparam int SW  = $clog2(TOT + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i, gorev_gecerli_i, iptal_i, res_gecerli_i, res_hazir_i;
  logic [1:0] gorev_kod_i, gorev_bitti_kod_o;
  logic gorev_hazir_o, filtre_gecerli_o, tu_basla_o, tu_iptal_o, gorev_bitti_o, mesgul_o, hata_o;
  logic [CB-1:0] filtre_veri_o;
  logic [3:0]    filtre_idx_o;
  logic [SW-1:0] islenen_sayac_o;

  gorev_denetleyici #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COEF_BIT(CB), .FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst_i), .gorev_kod_i(gorev_kod_i), .gorev_gecerli_i(gorev_gecerli_i),
    .gorev_hazir_o(gorev_hazir_o), .filtre_veri_o(filtre_veri_o), .filtre_idx_o(filtre_idx_o),
    .filtre_gecerli_o(filtre_gecerli_o), .tu_basla_o(tu_basla_o), .tu_iptal_o(tu_iptal_o),
    .res_gecerli_i(res_gecerli_i), .res_hazir_i(res_hazir_i), .gorev_bitti_o(gorev_bitti_o),
    .gorev_bitti_kod_o(gorev_bitti_kod_o), .islenen_sayac_o(islenen_sayac_o),
    .mesgul_o(mesgul_o), .hata_o(hata_o), .iptal_i(iptal_i));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Kernel table, row-major.
  int K [4][9] = '{'{-1, 0, 1, -2, 0, 2, -1, 0, 1},
                   '{-1, -2, -1, 0, 0, 0, 1, 2, 1},
                   '{0, 1, 0, 1, -4, 1, 0, 1, 0},
                   '{1, 1, 1, 1, 1, 1, 1, 1, 1}};

  // Reference model: pending codes, current task phase, coefficient index and result count.
  typedef enum {P_IDLE, P_LOAD, P_START, P_RUN, P_DONE} ph_t;
  ph_t        ph = P_IDLE;
  int         mk = 0, mcnt = 0;
  logic [1:0] run_code = '0;
  bit         m_iptal = 0, m_hata = 0, mon_on = 0, force_hs = 0;
  logic [1:0] model_q [$];
  logic [1:0] done_log [$];

  // Monitor: compare the current cycle, then advance the model by the inputs of the next edge.
  initial begin : monitor
    logic [CB-1:0] ev;
    bit hs, exp_hz;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        chk("filtre_gecerli", 32'(filtre_gecerli_o), 32'(ph == P_LOAD));
        if (ph == P_LOAD) begin
          ev = CB'(K[run_code][mk]);
          chk("filtre_idx", 32'(filtre_idx_o), 32'(mk));
          chk("filtre_veri", 32'(filtre_veri_o), 32'(ev));
        end
        chk("tu_basla", 32'(tu_basla_o), 32'(ph == P_START));
        chk("gorev_bitti", 32'(gorev_bitti_o), 32'(ph == P_DONE));
        if (ph == P_DONE && gorev_bitti_o) begin
          chk("bitti_kod", 32'(gorev_bitti_kod_o), 32'(run_code));
          done_log.push_back(gorev_bitti_kod_o);
        end
        chk("islenen", 32'(islenen_sayac_o), 32'(mcnt));
        chk("mesgul", 32'(mesgul_o), 32'(ph != P_IDLE));
        chk("tu_iptal", 32'(tu_iptal_o), 32'(m_iptal));
        chk("hata", 32'(hata_o), 32'(m_hata));
        exp_hz = (model_q.size() < D) && !iptal_i;
        chk("gorev_hazir", 32'(gorev_hazir_o), 32'(exp_hz));

        hs = res_gecerli_i && res_hazir_i;
        m_iptal = 0;
        if (rst_i) begin
          ph = P_IDLE; mk = 0; mcnt = 0; m_hata = 0;
          model_q.delete();
        end else begin
          if (hs && ph != P_RUN) m_hata = 1;
          if (iptal_i) begin
            ph = P_IDLE; mk = 0; mcnt = 0; m_iptal = 1;
            model_q.delete();
          end else begin
            case (ph)
              P_IDLE:  if (model_q.size() > 0) begin run_code = model_q.pop_front(); mk = 0; ph = P_LOAD; end
              P_LOAD:  if (mk == 8) ph = P_START; else mk++;
              P_START: begin mcnt = 0; ph = P_RUN; end
              P_RUN:   if (hs) begin mcnt++; if (mcnt == TOT) ph = P_DONE; end
              default: ph = P_IDLE;
            endcase
            if (gorev_gecerli_i && exp_hz) model_q.push_back(gorev_kod_i);
          end
        end
      end
    end
  end

  // Result-side traffic: random valid/ready only while a task is running.
  initial begin : res_drv
    res_gecerli_i = 1'b0;
    res_hazir_i   = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (force_hs) begin
        res_gecerli_i = 1'b1; res_hazir_i = 1'b1;
      end else if (ph == P_RUN) begin
        res_gecerli_i = ($urandom_range(0, 3) != 0);
        res_hazir_i   = ($urandom_range(0, 3) != 0);
      end else begin
        res_gecerli_i = 1'b0; res_hazir_i = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] code);
    gorev_gecerli_i = 1'b1;
    gorev_kod_i     = code;
    tick();
    gorev_gecerli_i = 1'b0;
  endtask

  task automatic wait_ph(input ph_t p, input int arg, input string nm);
    int n = 0;
    while (!(ph == p && (p != P_LOAD || mk == arg) && (p != P_RUN || mcnt >= arg)) && n < 3000) begin
      tick();
      n++;
    end
    chk({"wait_", nm}, 32'(n < 3000), 32'(1));
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!(ph == P_IDLE && model_q.size() == 0) && n < 20000) begin
      tick();
      n++;
    end
    chk({"idle_", nm}, 32'(n < 20000), 32'(1));
  endtask

  logic [1:0] b2b [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] ord [5] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

  initial begin : main
    rst_i = 1'b1; gorev_gecerli_i = 1'b0; gorev_kod_i = '0; iptal_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1;
    @(negedge clk);
    chk("rst_filtre_gecerli", 32'(filtre_gecerli_o), 0);
    chk("rst_filtre_veri", 32'(filtre_veri_o), 0);
    chk("rst_filtre_idx", 32'(filtre_idx_o), 0);
    chk("rst_basla", 32'(tu_basla_o), 0);
    chk("rst_iptal", 32'(tu_iptal_o), 0);
    chk("rst_bitti", 32'(gorev_bitti_o), 0);
    chk("rst_bitti_kod", 32'(gorev_bitti_kod_o), 0);
    chk("rst_islenen", 32'(islenen_sayac_o), 0);
    chk("rst_mesgul", 32'(mesgul_o), 0);
    chk("rst_hata", 32'(hata_o), 0);
    chk("rst_hazir", 32'(gorev_hazir_o), 1);
    tick();
    rst_i = 1'b0;

    // Sobel-X load latency: nothing in the cycle after the push edge, strobe idx 0 the next.
    push(2'd0);
    @(negedge clk);
    chk("lat_bosta", 32'(filtre_gecerli_o), 0);
    @(negedge clk);
    chk("lat_strobe", 32'(filtre_gecerli_o), 1);
    chk("lat_idx0", 32'(filtre_idx_o), 0);
    chk("lat_mesgul", 32'(mesgul_o), 1);
    tick();
    wait_idle("t1");

    // Box kernel through a full image with random stalls.
    done_log.delete();
    push(2'd3);
    wait_idle("t2");
    @(negedge clk);
    chk("t2_done_count", 32'(done_log.size()), 1);
    chk("t2_islenen", 32'(islenen_sayac_o), 32'(TOT));
    tick();

    // Result handshake while idle is a protocol error.
    force_hs = 1;
    tick();
    force_hs = 0;
    tick();
    @(negedge clk);
    chk("hata_set", 32'(hata_o), 1);
    tick();

    // Fill the queue behind a running task; the fifth push must be refused.
    done_log.delete();
    push(2'd3);
    wait_ph(P_LOAD, 0, "t3_load");
    gorev_gecerli_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      gorev_kod_i = b2b[i];
      @(negedge clk);
      chk("b2b_hazir", 32'(gorev_hazir_o), 32'(i < 4));
      tick();
    end
    gorev_gecerli_i = 1'b0;
    wait_idle("t3");
    chk("t3_done_count", 32'(done_log.size()), 5);
    for (int i = 0; i < 5 && i < done_log.size(); i++)
      chk("t3_order", 32'(done_log[i]), 32'(ord[i]));

    // Abort at count 100 with two tasks queued; a same-cycle push is refused.
    done_log.delete();
    push(2'd1);
    wait_ph(P_RUN, 0, "t4_run");
    push(2'd2);
    push(2'd0);
    wait_ph(P_RUN, 100, "t4_cnt");
    iptal_i = 1'b1;
    gorev_gecerli_i = 1'b1;
    gorev_kod_i = 2'd1;
    @(negedge clk);
    chk("iptal_hazir", 32'(gorev_hazir_o), 0);
    tick();
    iptal_i = 1'b0;
    gorev_gecerli_i = 1'b0;
    @(negedge clk);
    chk("iptal_pulse", 32'(tu_iptal_o), 1);
    chk("iptal_mesgul", 32'(mesgul_o), 0);
    chk("iptal_bitti", 32'(gorev_bitti_o), 0);
    repeat (4) tick();
    @(negedge clk);
    chk("iptal_pulse_end", 32'(tu_iptal_o), 0);
    chk("iptal_flushed", 32'(mesgul_o), 0);
    chk("iptal_no_done", 32'(done_log.size()), 0);
    chk("hata_kept", 32'(hata_o), 1);
    tick();

    // Reset in the middle of the coefficient load.
    push(2'd2);
    wait_ph(P_LOAD, 4, "t6_k4");
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    chk("mrst_strobe", 32'(filtre_gecerli_o), 0);
    chk("mrst_mesgul", 32'(mesgul_o), 0);
    chk("mrst_hata", 32'(hata_o), 0);
    chk("mrst_islenen", 32'(islenen_sayac_o), 0);
    chk("mrst_veri", 32'(filtre_veri_o), 0);
    repeat (3) tick();
    @(negedge clk);
    chk("mrst_queue_empty", 32'(mesgul_o), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
